rv32m_mul_unit: RTL and testbench
=================================

# rv32m_mul_unit

Parametrised, fully pipelined integer multiplier implementing all four RV32M multiply operations (MUL, MULH, MULHSU, MULHU), with a destination tag carried alongside each operation. It is the successor to the fixed-width unsigned pipelined multiplier and sits in the execute stage beside the ALU. It accepts one operation per cycle under valid/ready handshakes on both sides, supports downstream backpressure, and provides a flush that kills all in-flight operations on a pipeline redirect.

## Interface
- XLEN, 32, operand and result width (even, ≥ 8)
- STAGES, 3, pipeline depth = acceptance-to-result latency in cycles (1..6)
- TAG_W, 5, width of the pass-through tag (rd index)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_vld  in  1  input operation valid
- o_rdy  out  1  unit can accept an input this cycle
- i_op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- i_multiplicand  in  XLEN  rs1 operand
- i_multiplier  in  XLEN  rs2 operand
- i_tag  in  TAG_W  tag, returned unchanged with the result
- i_flush  in  1  kill all in-flight operations
- o_vld  out  1  result valid
- i_rdy  in  1  downstream can take the result
- o_product  out  XLEN  selected result word
- o_tag  out  TAG_W  tag of the result

## Operation
- Acceptance: an input is accepted when i_vld && o_rdy && !i_flush.
- Operand extension to XLEN+1 bits:
  - rs1 is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - rs2 is sign-extended for MULH only.
- Product: signed (XLEN+1)×(XLEN+1) multiply, truncated to 2·XLEN bits.
  - MUL returns bits [XLEN-1:0].
  - All other ops return bits [2·XLEN-1:XLEN].
  - The low word of MUL is independent of signedness.
- Pipeline: STAGES stages. Each stage holds a valid bit, the op, the tag and the datapath state.
  - Stage 0 registers the extended operands.
  - The multiply is registered at the end of stage 0, or split over stages 0..1 when STAGES ≥ 2.
  - The remaining stages are plain registers, available for synthesis retiming.
  - The result word is selected at the last stage.
- Ready chain: rdy_k = !v_k || rdy_(k+1), with rdy_STAGES = i_rdy.
  - o_rdy = rdy_0 && !i_flush. The combinational path from i_rdy to o_rdy is permitted.
  - A stage loads when its own rdy is high. Bubbles collapse under stall.
- Output:
  - o_vld = v_last && !i_flush.
  - o_product and o_tag come from last-stage registers and are held stable while o_vld && !i_rdy.
- Flush: on the edge following a cycle with i_flush high, every valid bit clears. No input is accepted in the flush cycle. Data registers may retain stale values.

## Timing
- Reset values:
  - All valid bits 0.
  - o_vld 0, o_product 0, o_tag 0.
  - o_rdy 1 once rstn is deasserted and i_flush is low.
- Latency: an input accepted at edge N produces o_vld high after edge N+STAGES, provided there is no stall.
- Throughput: 1 op/cycle while i_rdy is held high.
- Stall: with i_rdy low, the last stage holds. Upstream stages fill until all are valid, then o_rdy drops. Ordering is always preserved.
- Simultaneous output handshake and input acceptance in the same cycle is legal with a full pipeline. o_rdy stays high if i_rdy is high.
- Flush has priority over accept and over the output handshake. In the flush cycle o_vld reads 0, so no result is consumed.
- Reset mid-operation clears all in-flight ops asynchronously. No result is emitted for them.

## Structure
- Shared package rv32m_pkg:
  - mul_op_e enum (MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11).
  - Helper functions for operand-signedness decode.
- One sub-module, rv32m_pipe_stage: a parametrised stage register holding valid, op, tag and a data payload of parameter width, with load/flush/reset. It is instantiated per stage via generate.
- The top level holds operand extension, the multiply, the ready chain and result selection.

## Test plan
- MUL 0x0000BEEF × 0x000000CA, i_rdy=1 → o_product 0x0096A896 exactly STAGES cycles after acceptance, with tag echoed.
- Operands 0xFFFFFFFF × 0xFFFFFFFF, issued back-to-back as MUL, MULH, MULHSU, MULHU on consecutive cycles → 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE in order on consecutive cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0x80000000 × 0x80000000 → 0xC0000000.
- i_rdy low for 5 cycles during a stream of 6 ops:
  - o_rdy drops once STAGES ops are held.
  - o_product and o_tag stay stable while stalled.
  - All 6 results emerge in order with none lost or duplicated.
- Assert i_flush for one cycle with 3 ops in flight and i_vld high:
  - No result for those ops and no acceptance that cycle.
  - The next op issued afterwards returns correctly after STAGES cycles.
- Assert rstn low mid-stream → o_vld 0 immediately. After release, o_rdy is 1 and new ops compute correctly. Repeat the suite with XLEN=16, STAGES=1 and XLEN=32, STAGES=5.

Source files
------------

// File: rtl/rv32m_pkg.sv
// rv32m_pkg: RV32M multiply op encoding and operand-signedness decode.
package rv32m_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    function automatic logic rs1_signed(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic rs2_signed(input mul_op_e op);
        return op == MULH;
    endfunction

    function automatic logic sel_high(input mul_op_e op);
        return op != MUL;
    endfunction

endpackage

// File: rtl/rv32m_pipe_stage.sv
// rv32m_pipe_stage: one pipeline slot holding valid, op, tag and a data payload.
module rv32m_pipe_stage
    import rv32m_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DW    = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic             i_vld,
    input  mul_op_e          i_op,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [DW-1:0]    i_data,
    output logic             o_vld,
    output mul_op_e          o_op,
    output logic [TAG_W-1:0] o_tag,
    output logic [DW-1:0]    o_data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vld  <= 1'b0;
            o_op   <= MUL;
            o_tag  <= '0;
            o_data <= '0;
        end else begin
            if (i_flush)
                o_vld <= 1'b0;
            else if (i_load)
                o_vld <= i_vld;
            if (i_load) begin
                o_op   <= i_op;
                o_tag  <= i_tag;
                o_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/rv32m_mul_unit.sv
// rv32m_mul_unit: fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// with tag pass-through, valid/ready backpressure and flush.
module rv32m_mul_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [1:0]       i_op,
    input  logic [XLEN-1:0]  i_multiplicand,
    input  logic [XLEN-1:0]  i_multiplier,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [XLEN-1:0]  o_product,
    output logic [TAG_W-1:0] o_tag
);

    localparam int PW = 2 * XLEN;

    // Sign-extending both XLEN+1 operands to 2*XLEN makes a plain multiply
    // yield the exact low 2*XLEN bits of the signed product.
    function automatic logic [PW-1:0] smul(input logic [XLEN:0] a, input logic [XLEN:0] b);
        return {{(XLEN-1){a[XLEN]}}, a} * {{(XLEN-1){b[XLEN]}}, b};
    endfunction

    mul_op_e           w_op_in;
    logic [XLEN:0]     w_a;
    logic [XLEN:0]     w_b;
    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_v;
    mul_op_e           w_op  [STAGES];
    logic [TAG_W-1:0]  w_tag [STAGES];
    logic [PW-1:0]     w_d   [STAGES];

    assign w_op_in       = mul_op_e'(i_op);
    assign w_a           = {rs1_signed(w_op_in) & i_multiplicand[XLEN-1], i_multiplicand};
    assign w_b           = {rs2_signed(w_op_in) & i_multiplier[XLEN-1], i_multiplier};
    assign w_rdy[STAGES] = i_rdy;

    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign w_rdy[k] = !w_v[k] || w_rdy[k+1];
    end

    if (STAGES == 1) begin : g_single
        rv32m_pipe_stage #(.TAG_W(TAG_W), .DW(PW)) u_s0 (
            .clk(clk), .rstn(rstn), .i_load(w_rdy[0]), .i_flush(i_flush),
            .i_vld(i_vld), .i_op(w_op_in), .i_tag(i_tag), .i_data(smul(w_a, w_b)),
            .o_vld(w_v[0]), .o_op(w_op[0]), .o_tag(w_tag[0]), .o_data(w_d[0])
        );
    end else begin : g_multi
        logic [2*XLEN+1:0] w_ops;
        rv32m_pipe_stage #(.TAG_W(TAG_W), .DW(2*XLEN+2)) u_s0 (
            .clk(clk), .rstn(rstn), .i_load(w_rdy[0]), .i_flush(i_flush),
            .i_vld(i_vld), .i_op(w_op_in), .i_tag(i_tag), .i_data({w_a, w_b}),
            .o_vld(w_v[0]), .o_op(w_op[0]), .o_tag(w_tag[0]), .o_data(w_ops)
        );
        // Slot 0 of the data array carries the unregistered product between stages 0 and 1.
        assign w_d[0] = smul(w_ops[2*XLEN+1:XLEN+1], w_ops[XLEN:0]);
        for (genvar k = 1; k < STAGES; k++) begin : g_stage
            rv32m_pipe_stage #(.TAG_W(TAG_W), .DW(PW)) u_s (
                .clk(clk), .rstn(rstn), .i_load(w_rdy[k]), .i_flush(i_flush),
                .i_vld(w_v[k-1]), .i_op(w_op[k-1]), .i_tag(w_tag[k-1]), .i_data(w_d[k-1]),
                .o_vld(w_v[k]), .o_op(w_op[k]), .o_tag(w_tag[k]), .o_data(w_d[k])
            );
        end
    end

    assign o_rdy     = w_rdy[0] && !i_flush;
    assign o_vld     = w_v[STAGES-1] && !i_flush;
    assign o_tag     = w_tag[STAGES-1];
    assign o_product = sel_high(w_op[STAGES-1]) ? w_d[STAGES-1][PW-1:XLEN] : w_d[STAGES-1][XLEN-1:0];

endmodule

// File: tb/tb_rv32m_mul_unit.sv
// tb_rv32m_mul_unit: drives three configurations (32/3, 16/1, 32/5) from one
// directed+random sequence and scores each against an arithmetic model.
module tb_rv32m_mul_unit;

    typedef struct {
        logic [31:0] p;
        logic [4:0]  t;
        int          c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_vld;
    logic [1:0]  i_op;
    logic [4:0]  i_tag;
    logic        i_flush;
    logic        i_rdy;
    logic [31:0] opa [3];
    logic [31:0] opb [3];
    logic        o_rdy_a  [3];
    logic        o_vld_a  [3];
    logic [31:0] o_prod_a [3];
    logic [4:0]  o_tag_a  [3];

    int xw [3] = '{32, 16, 32};
    int st [3] = '{3, 1, 5};

    ent_t        q   [3][$];
    logic [31:0] got [3][$];
    logic        hold [3];
    logic [31:0] pp   [3];
    logic [4:0]  pt   [3];
    int          acc  [3];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          last_stall = -1;
    bit          dir = 1'b0;

    logic [31:0] k32 [7] = '{32'h0096A896, 32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'hC0000000};
    logic [31:0] k16 [7] = '{32'hA896, 32'h1, 32'h0, 32'hFFFF, 32'hFFFE, 32'h4000, 32'hC000};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int XL = (g == 1) ? 16 : 32;
        localparam int SG = (g == 0) ? 3 : ((g == 1) ? 1 : 5);
        logic [XL-1:0] w_p;
        rv32m_mul_unit #(.XLEN(XL), .STAGES(SG), .TAG_W(5)) u_dut (
            .clk(clk), .rstn(rstn), .i_vld(i_vld), .o_rdy(o_rdy_a[g]), .i_op(i_op),
            .i_multiplicand(opa[g][XL-1:0]), .i_multiplier(opb[g][XL-1:0]), .i_tag(i_tag),
            .i_flush(i_flush), .o_vld(o_vld_a[g]), .i_rdy(i_rdy), .o_product(w_p), .o_tag(o_tag_a[g])
        );
        assign o_prod_a[g] = 32'(w_p);
    end

    // Reference: treat operands as w-bit integers, signed per op, multiply, pick a word.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        longint m, x, y, p;
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if ((op == 2'b01 || op == 2'b10) && a[w-1]) x -= longint'(1) << w;
        if (op == 2'b01 && b[w-1]) y -= longint'(1) << w;
        p = x * y;
        return 32'(((op == 2'b00) ? p : (p >>> w)) & m);
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h, expected %h", nm, g, obs, exp);
        end
    endtask

    task automatic tick();
        ent_t e;
        #1;
        for (int g = 0; g < 3; g++) begin
            if (i_flush) begin
                chk("flush_o_vld", g, 64'(o_vld_a[g]), 64'd0);
                chk("flush_o_rdy", g, 64'(o_rdy_a[g]), 64'd0);
            end
            if (hold[g]) begin
                chk("stall_product", g, 64'(o_prod_a[g]), 64'(pp[g]));
                chk("stall_tag", g, 64'(o_tag_a[g]), 64'(pt[g]));
            end
            if (o_vld_a[g] && i_rdy) begin
                chk("result_expected", g, 64'(q[g].size() != 0), 64'd1);
                if (q[g].size() != 0) begin
                    e = q[g].pop_front();
                    chk("product", g, 64'(o_prod_a[g]), 64'(e.p));
                    chk("tag", g, 64'(o_tag_a[g]), 64'(e.t));
                    if (last_stall < e.c)
                        chk("latency", g, 64'(cyc - e.c), 64'(st[g]));
                    else
                        chk("latency_min", g, 64'(cyc - e.c >= st[g]), 64'd1);
                    if (dir) got[g].push_back(o_prod_a[g]);
                end
            end
            if (i_vld && o_rdy_a[g] && !i_flush) begin
                q[g].push_back('{model(i_op, opa[g], opb[g], xw[g]), i_tag, cyc});
                acc[g]++;
            end
            if (i_flush) q[g].delete();
            hold[g] = o_vld_a[g] && !i_rdy;
            pp[g] = o_prod_a[g];
            pt[g] = o_tag_a[g];
        end
        if (!i_rdy) last_stall = cyc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_vld = 1'b0;
        i_flush = 1'b0;
        repeat (n) tick();
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] a16, input logic [31:0] b16, input logic [4:0] tag);
        i_vld = 1'b1;
        i_op = op;
        i_tag = tag;
        opa[0] = a; opa[2] = a; opa[1] = a16;
        opb[0] = b; opb[2] = b; opb[1] = b16;
        tick();
    endtask

    function automatic logic [31:0] pick();
        logic [1:0] r;
        r = 2'($urandom);
        return (r == 2'd0) ? 32'h0 : (r == 2'd1) ? 32'hFFFFFFFF : (r == 2'd2) ? 32'h80000000 : $urandom;
    endfunction

    task automatic rnd_op();
        logic [31:0] va, vb;
        va = pick();
        vb = pick();
        i_vld = 1'b1;
        i_op = 2'($urandom);
        i_tag = 5'($urandom);
        opa[0] = va; opa[2] = va; opa[1] = {16'h0, va[31:16]};
        opb[0] = vb; opb[2] = vb; opb[1] = {16'h0, vb[31:16]};
    endtask

    task automatic reset_model();
        for (int g = 0; g < 3; g++) begin
            q[g].delete();
            hold[g] = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0; i_vld = 1'b0; i_op = 2'b00; i_tag = '0; i_flush = 1'b0; i_rdy = 1'b1;
        for (int g = 0; g < 3; g++) begin
            opa[g] = '0; opb[g] = '0; hold[g] = 1'b0; acc[g] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("reset_o_vld", g, 64'(o_vld_a[g]), 64'd0);
            chk("reset_o_product", g, 64'(o_prod_a[g]), 64'd0);
            chk("reset_o_tag", g, 64'(o_tag_a[g]), 64'd0);
        end
        rstn = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) chk("post_reset_o_rdy", g, 64'(o_rdy_a[g]), 64'd1);
        @(negedge clk);

        dir = 1'b1;
        issue(2'b00, 32'h0000BEEF, 32'h000000CA, 32'hBEEF, 32'h00CA, 5'd1);
        idle(7);
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF, 32'hFFFF, 5'd2);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF, 32'hFFFF, 5'd3);
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF, 32'hFFFF, 5'd4);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF, 32'hFFFF, 5'd5);
        idle(7);
        issue(2'b01, 32'h80000000, 32'h80000000, 32'h8000, 32'h8000, 5'd6);
        issue(2'b10, 32'h80000000, 32'h80000000, 32'h8000, 32'h8000, 5'd7);
        idle(7);
        dir = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("directed_count", g, 64'(got[g].size()), 64'd7);
            for (int i = 0; i < 7 && i < got[g].size(); i++)
                chk("directed_value", g, 64'(got[g][i]), 64'((g == 1) ? k16[i] : k32[i]));
        end

        // Backpressure: hold i_rdy low while streaming, then release.
        for (int g = 0; g < 3; g++) acc[g] = 0;
        i_rdy = 1'b0;
        repeat (7) begin
            rnd_op();
            tick();
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("stall_accepted", g, 64'(acc[g]), 64'(st[g]));
            chk("stall_o_rdy", g, 64'(o_rdy_a[g]), 64'd0);
        end
        i_rdy = 1'b1;
        repeat (6) begin
            rnd_op();
            tick();
        end
        idle(10);

        // Flush with ops in flight and a new op offered in the same cycle.
        repeat (3) begin
            rnd_op();
            tick();
        end
        rnd_op();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        rnd_op();
        tick();
        idle(8);

        // Asynchronous reset mid-stream.
        repeat (3) begin
            rnd_op();
            tick();
        end
        i_vld = 1'b0;
        rstn = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) chk("async_reset_o_vld", g, 64'(o_vld_a[g]), 64'd0);
        reset_model();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) chk("rerelease_o_rdy", g, 64'(o_rdy_a[g]), 64'd1);
        @(negedge clk);
        issue(2'b11, 32'hDEADBEEF, 32'h12345678, 32'hBEEF, 32'h5678, 5'd9);
        idle(8);

        // Random traffic with backpressure and occasional flushes.
        repeat (1500) begin
            rnd_op();
            i_vld = ($urandom % 4) != 0;
            i_rdy = ($urandom % 4) != 0;
            i_flush = ($urandom % 64) == 0;
            tick();
        end
        i_rdy = 1'b1;
        idle(20);
        for (int g = 0; g < 3; g++) chk("drained", g, 64'(q[g].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
